ex_branch_resolve: RTL and testbench

//  Execute-stage consumer of the ID/EX register fields. Resolves SPARC control transfers (Bicc, CALL, JMPL).

---
 rtl/sparc_pkg.sv | 26 ++
 rtl/sparc_cond_eval.sv | 31 +++
 rtl/ex_branch_resolve.sv | 139 +++++++++++++
 tb/tb_ex_branch_resolve.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sparc_pkg.sv
// Shared SPARC control-transfer decode constants and types for the execute-stage branch unit.
package sparc_pkg;

    localparam logic [1:0] OP_BR   = 2'b00;
    localparam logic [1:0] OP_CALL = 2'b01;
    localparam logic [1:0] OP_ALU  = 2'b10;

    localparam logic [2:0] OP2_BICC = 3'b010;
    localparam logic [5:0] OP3_JMPL = 6'b111000;

    // Bicc condition encodings: the upper half is the complement of the lower half.
    typedef enum logic [3:0] {
        BN, BE, BLE, BL, BLEU, BCS, BNEG, BVS,
        BA, BNE, BG, BGE, BGU, BCC, BPOS, BVC
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } icc_t;

    typedef enum logic [1:0] {IDLE, DELAY, ANNUL} br_state_e;

endpackage

// File: rtl/sparc_cond_eval.sv
// Combinational Bicc condition evaluation against a set of integer condition codes.
module sparc_cond_eval
    import sparc_pkg::*;
(
    input  cond_e i_cond,
    input  icc_t  i_icc,
    output logic  o_taken
);

    logic [3:0] w_cond;
    logic       w_base;

    assign w_cond = i_cond;

    always_comb begin
        w_base = 1'b0;
        case (w_cond[2:0])
            3'b000:  w_base = 1'b0;
            3'b001:  w_base = i_icc.z;
            3'b010:  w_base = i_icc.z | (i_icc.n ^ i_icc.v);
            3'b011:  w_base = i_icc.n ^ i_icc.v;
            3'b100:  w_base = i_icc.c | i_icc.z;
            3'b101:  w_base = i_icc.c;
            3'b110:  w_base = i_icc.n;
            default: w_base = i_icc.v;
        endcase
    end

    assign o_taken = w_base ^ w_cond[3];

endmodule

// File: rtl/ex_branch_resolve.sv
// Execute-stage resolution of Bicc/CALL/JMPL with icc ownership and delay-slot annul FSM.
// Optional taken/untaken counters are built when BRANCH_STATS_EN is defined.
module ex_branch_resolve
    import sparc_pkg::*;
#(
    parameter int PC_SIZE   = 32,
    parameter int INST_SIZE = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ex_valid,
    input  logic                 i_stall,
    input  logic [1:0]           i_op,
    input  logic [2:0]           i_op2,
    input  logic [5:0]           i_op3,
    input  logic [3:0]           i_cond,
    input  logic                 i_a,
    input  logic                 i_i,
    input  logic [12:0]          i_imm13,
    input  logic [21:0]          i_disp22,
    input  logic [29:0]          i_disp30,
    input  logic [PC_SIZE-1:0]   i_pc_plus4,
    input  logic [INST_SIZE-1:0] i_valA,
    input  logic [INST_SIZE-1:0] i_valB,
    input  logic                 i_icc_we,
    input  logic [3:0]           i_icc_in,
    output logic                 o_redirect,
    output logic [PC_SIZE-1:0]   o_redirect_pc,
    output logic                 o_ex_squash,
    output logic                 o_misalign,
    output logic [3:0]           o_icc_out,
    output logic [31:0]          o_stat_taken,
    output logic [31:0]          o_stat_untaken
);

    br_state_e r_state, w_next_state;
    icc_t      r_icc, w_icc_eval;

    logic                 r_redirect, r_misalign;
    logic [PC_SIZE-1:0]   r_redirect_pc;
    logic                 w_is_bicc, w_is_call, w_is_jmpl, w_jmpl_bad;
    logic                 w_cond_true, w_active, w_taken, w_annul, w_resolves;
    logic [PC_SIZE-1:0]   w_pc, w_bicc_tgt, w_call_tgt, w_jmpl_tgt, w_target;
    logic [INST_SIZE-1:0] w_jmpl_off, w_jmpl_sum;

    assign w_is_bicc = (i_op == OP_BR)  && (i_op2 == OP2_BICC);
    assign w_is_call = (i_op == OP_CALL);
    assign w_is_jmpl = (i_op == OP_ALU) && (i_op3 == OP3_JMPL);

    assign w_pc       = i_pc_plus4 - PC_SIZE'(4);
    assign w_bicc_tgt = w_pc + (PC_SIZE'($signed(i_disp22)) << 2);
    assign w_call_tgt = w_pc + PC_SIZE'({i_disp30, 2'b00});
    assign w_jmpl_off = i_i ? INST_SIZE'($signed(i_imm13)) : i_valB;
    assign w_jmpl_sum = i_valA + w_jmpl_off;
    assign w_jmpl_tgt = PC_SIZE'(w_jmpl_sum);
    assign w_jmpl_bad = w_is_jmpl && (w_jmpl_sum[1:0] != 2'b00);

    assign w_target = w_is_bicc ? w_bicc_tgt : (w_is_call ? w_call_tgt : w_jmpl_tgt);

    // Bicc sees the flags being written this cycle by the older ALU op.
    assign w_icc_eval = i_icc_we ? icc_t'(i_icc_in) : r_icc;

    sparc_cond_eval u_cond_eval (
        .i_cond  (cond_e'(i_cond)),
        .i_icc   (w_icc_eval),
        .o_taken (w_cond_true)
    );

    assign w_active   = i_ex_valid && !i_stall && !o_ex_squash;
    assign w_taken    = w_is_call || (w_is_jmpl && !w_jmpl_bad) || (w_is_bicc && w_cond_true);
    assign w_annul    = w_is_bicc && i_a && (!w_cond_true || (i_cond == BA));
    assign w_resolves = w_active && (w_is_call || w_is_bicc || (w_is_jmpl && !w_jmpl_bad));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next_state;
    end

    // A CTI in the delay slot re-arms the FSM just as it would from IDLE.
    always_comb begin
        w_next_state = r_state;
        if (!i_stall) begin
            case (r_state)
                IDLE, DELAY: begin
                    if (w_active)
                        w_next_state = w_resolves ? (w_annul ? ANNUL : DELAY) : IDLE;
                end
                ANNUL: begin
                    if (i_ex_valid) w_next_state = IDLE;
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        o_ex_squash = (r_state == ANNUL) && i_ex_valid;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_icc         <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_misalign    <= 1'b0;
        end else begin
            if (!i_stall && i_icc_we) r_icc <= icc_t'(i_icc_in);
            r_redirect <= w_active && w_taken;
            r_misalign <= w_active && w_jmpl_bad;
            if (w_active && w_taken) r_redirect_pc <= w_target;
        end
    end

    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;
    assign o_misalign    = r_misalign;
    assign o_icc_out     = r_icc;

`ifdef BRANCH_STATS_EN
    logic [31:0] r_stat_taken, r_stat_untaken;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_taken   <= '0;
            r_stat_untaken <= '0;
        end else begin
            if (w_active && w_taken)                 r_stat_taken   <= r_stat_taken + 32'd1;
            if (w_active && w_is_bicc && !w_cond_true) r_stat_untaken <= r_stat_untaken + 32'd1;
        end
    end

    assign o_stat_taken   = r_stat_taken;
    assign o_stat_untaken = r_stat_untaken;
`else
    assign o_stat_taken   = '0;
    assign o_stat_untaken = '0;
`endif

endmodule

// File: tb/tb_ex_branch_resolve.sv
// Directed self-checking bench for ex_branch_resolve (Bicc/CALL/JMPL, annul FSM, icc bypass, reset).
module tb_ex_branch_resolve;

    logic        clk;
    logic        rstN;
    logic        exValid, stall;
    logic [1:0]  op;
    logic [2:0]  op2;
    logic [5:0]  op3;
    logic [3:0]  cond;
    logic        aBit, iBit;
    logic [12:0] imm13;
    logic [21:0] disp22;
    logic [29:0] disp30;
    logic [31:0] pcPlus4, valA, valB;
    logic        iccWe;
    logic [3:0]  iccIn;
    logic        redirect, exSquash, misalign;
    logic [31:0] redirectPc, statTaken, statUntaken;
    logic [3:0]  iccOut;

    int testCount = 0;
    int failCount = 0;

    ex_branch_resolve #(.PC_SIZE(32), .INST_SIZE(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_ex_valid     (exValid),
        .i_stall        (stall),
        .i_op           (op),
        .i_op2          (op2),
        .i_op3          (op3),
        .i_cond         (cond),
        .i_a            (aBit),
        .i_i            (iBit),
        .i_imm13        (imm13),
        .i_disp22       (disp22),
        .i_disp30       (disp30),
        .i_pc_plus4     (pcPlus4),
        .i_valA         (valA),
        .i_valB         (valB),
        .i_icc_we       (iccWe),
        .i_icc_in       (iccIn),
        .o_redirect     (redirect),
        .o_redirect_pc  (redirectPc),
        .o_ex_squash    (exSquash),
        .o_misalign     (misalign),
        .o_icc_out      (iccOut),
        .o_stat_taken   (statTaken),
        .o_stat_untaken (statUntaken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleSlot();
        exValid = 1'b0; op = 2'b10; op2 = 3'b000; op3 = 6'b000000;
        cond = 4'b0000; aBit = 1'b0; iBit = 1'b0; imm13 = '0; disp22 = '0; disp30 = '0;
        valA = '0; valB = '0; iccWe = 1'b0; iccIn = 4'b0000; stall = 1'b0;
    endtask

    task automatic aluOp(input logic we, input logic [3:0] flags);
        idleSlot();
        exValid = 1'b1; iccWe = we; iccIn = flags;
    endtask

    task automatic applyStimulus(input logic [3:0] c, input logic an, input logic [31:0] pc4, input logic [21:0] d22);
        idleSlot();
        exValid = 1'b1; op = 2'b00; op2 = 3'b010; op3 = 6'b010000;
        cond = c; aBit = an; pcPlus4 = pc4; disp22 = d22;
    endtask

    task automatic jmplOp(input logic [31:0] ra, input logic useImm, input logic [12:0] imm, input logic [31:0] rb);
        idleSlot();
        exValid = 1'b1; op = 2'b10; op3 = 6'b111000; valA = ra; iBit = useImm; imm13 = imm; valB = rb;
    endtask

    initial begin
        idleSlot();
        pcPlus4 = '0;
        rstN = 1'b0;
        #12;
        checkOutput("reset_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("reset_redirect_pc", redirectPc, 32'd0);
        checkOutput("reset_icc", {28'd0, iccOut}, 32'd0);
        checkOutput("reset_misalign", {31'd0, misalign}, 32'd0);
        checkOutput("reset_stat_taken", statTaken, 32'd0);
        rstN = 1'b1;
        tick();

        // 1: BE taken with Z set, delay slot executes
        aluOp(1'b1, 4'b0100);
        tick();
        checkOutput("t1_icc_set", {28'd0, iccOut}, 32'h4);
        applyStimulus(4'b0001, 1'b0, 32'h104, 22'h10);
        tick();
        checkOutput("t1_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("t1_redirect_pc", redirectPc, 32'h140);
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("t1_slot_not_squashed", {31'd0, exSquash}, 32'd0);
        tick();
        checkOutput("t1_redirect_one_cycle", {31'd0, redirect}, 32'd0);

        // 2: BNE,a untaken annuls the slot; invalid cycle holds ANNUL
        applyStimulus(4'b1001, 1'b1, 32'h204, 22'h10);
        tick();
        checkOutput("t2_no_redirect", {31'd0, redirect}, 32'd0);
        idleSlot();
        #1;
        checkOutput("t2_bubble_no_squash", {31'd0, exSquash}, 32'd0);
        tick();
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("t2_slot_squashed", {31'd0, exSquash}, 32'd1);
        tick();
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("t2_after_slot", {31'd0, exSquash}, 32'd0);
        tick();

        // 3: BA,a with negative displacement
        applyStimulus(4'b1000, 1'b1, 32'h200, 22'h3FFFFF);
        tick();
        checkOutput("t3_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("t3_redirect_pc", redirectPc, 32'h1F8);
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("t3_slot_squashed", {31'd0, exSquash}, 32'd1);
        tick();

        // Stall after a taken BE: pulse fires once, not repeated
        applyStimulus(4'b0001, 1'b0, 32'h304, 22'h1);
        tick();
        checkOutput("stall_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("stall_redirect_pc", redirectPc, 32'h304);
        stall = 1'b1;
        tick();
        checkOutput("stall_no_repeat", {31'd0, redirect}, 32'd0);
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("stall_slot_not_squashed", {31'd0, exSquash}, 32'd0);
        tick();

        // 4: icc bypass
        aluOp(1'b1, 4'b0000);
        tick();
        checkOutput("t4_icc_cleared", {28'd0, iccOut}, 32'd0);
        applyStimulus(4'b0001, 1'b0, 32'h304, 22'h2);
        iccWe = 1'b1; iccIn = 4'b0100;
        tick();
        checkOutput("t4_bypass_taken", {31'd0, redirect}, 32'd1);
        checkOutput("t4_bypass_pc", redirectPc, 32'h308);
        checkOutput("t4_icc_out", {28'd0, iccOut}, 32'h4);
        aluOp(1'b0, 4'b0000);
        tick();

        // CALL
        idleSlot();
        exValid = 1'b1; op = 2'b01; pcPlus4 = 32'h404; disp30 = 30'h10;
        tick();
        checkOutput("call_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("call_pc", redirectPc, 32'h440);
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("call_slot_not_squashed", {31'd0, exSquash}, 32'd0);
        tick();

        // 5: JMPL aligned, register-register, then misaligned
        jmplOp(32'h1000, 1'b1, 13'h1FFC, 32'h0);
        tick();
        checkOutput("t5_jmpl_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("t5_jmpl_pc", redirectPc, 32'hFFC);
        checkOutput("t5_jmpl_no_misalign", {31'd0, misalign}, 32'd0);
        aluOp(1'b0, 4'b0000);
        tick();
        jmplOp(32'h1000, 1'b0, 13'h0, 32'h20);
        tick();
        checkOutput("t5_jmpl_rr_pc", redirectPc, 32'h1020);
        aluOp(1'b0, 4'b0000);
        tick();
        jmplOp(32'h1000, 1'b1, 13'h0002, 32'h0);
        tick();
        checkOutput("t5_misalign", {31'd0, misalign}, 32'd1);
        checkOutput("t5_misalign_no_redirect", {31'd0, redirect}, 32'd0);
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("t5_misalign_no_squash", {31'd0, exSquash}, 32'd0);
        tick();
        checkOutput("t5_misalign_one_cycle", {31'd0, misalign}, 32'd0);

        // 6: async reset while in ANNUL with a redirect pending
        applyStimulus(4'b1000, 1'b1, 32'h504, 22'h1);
        tick();
        aluOp(1'b0, 4'b0000);
        #1;
        checkOutput("t6_pre_redirect", {31'd0, redirect}, 32'd1);
        checkOutput("t6_pre_squash", {31'd0, exSquash}, 32'd1);
        rstN = 1'b0;
        #1;
        checkOutput("t6_rst_redirect", {31'd0, redirect}, 32'd0);
        checkOutput("t6_rst_redirect_pc", redirectPc, 32'd0);
        checkOutput("t6_rst_squash", {31'd0, exSquash}, 32'd0);
        checkOutput("t6_rst_icc", {28'd0, iccOut}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        tick();

        // Counters: 3 taken + 2 untaken Bicc, each with a delay slot
        aluOp(1'b1, 4'b0100);
        tick();
        applyStimulus(4'b0001, 1'b0, 32'h600, 22'h4); tick(); aluOp(1'b0, 4'b0); tick();
        applyStimulus(4'b1001, 1'b0, 32'h700, 22'h4); tick(); aluOp(1'b0, 4'b0); tick();
        applyStimulus(4'b1000, 1'b0, 32'h800, 22'h4); tick(); aluOp(1'b0, 4'b0); tick();
        applyStimulus(4'b1001, 1'b0, 32'h900, 22'h4); tick(); aluOp(1'b0, 4'b0); tick();
        applyStimulus(4'b0001, 1'b0, 32'hA00, 22'h4); tick(); aluOp(1'b0, 4'b0); tick();
`ifdef BRANCH_STATS_EN
        checkOutput("stat_taken", statTaken, 32'd3);
        checkOutput("stat_untaken", statUntaken, 32'd2);
`else
        checkOutput("stat_taken_tied", statTaken, 32'd0);
        checkOutput("stat_untaken_tied", statUntaken, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
